// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared burst-format constants and decoder state encoding
package pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

  // Burst format agreed between the pulse-train generator and the decoder
  localparam int DEF_EXPECTED_PULSES = 8;
  localparam int DEF_GAP_CYCLES      = 3;

  // High-width and gap trackers saturate at 15
  localparam int TRACK_W = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear, load-to-one and saturate flag
module sat_counter #(
  parameter int W = 4
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  assign sat = (count == MAX);

  // Reset/clear to zero, load restarts at one, increment stops at all-ones
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= {{(W-1){1'b0}}, 1'b1};
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_burst_decoder.sv
// rtl/pulse_burst_decoder.sv - burst segmenter/verifier for a pulse train; PULSE_DEC_ERRCNT_EN adds err_count
module pulse_burst_decoder
  import pulse_pkg::*;
#(
  parameter int CNT_W           = 5,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int EXPECTED_PULSES = DEF_EXPECTED_PULSES,
  parameter int MAX_WIDTH       = 1,
  parameter int TOTAL_W         = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse,
  input  logic               clear,
  output logic               burst_done,
  output logic [CNT_W-1:0]   burst_len,
  output logic               burst_ok,
  output logic               busy,
  output logic [TOTAL_W-1:0] burst_total
`ifdef PULSE_DEC_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);

  localparam logic [TRACK_W-1:0] GAP_LAST = TRACK_W'(GAP_CYCLES - 1);
  localparam logic [TRACK_W-1:0] MAX_W    = TRACK_W'(MAX_WIDTH);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_sat, cnt_load, cnt_inc;
  logic [TRACK_W-1:0]   width;
  logic                 width_sat, width_load, width_inc;
  logic [TRACK_W-1:0]   gap;
  logic                 gap_start, gap_inc;
  logic                 burst_start, set_wide, set_ovf, done_enter;
  logic                 wide_err, ovf;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (cnt),
    .sat   (cnt_sat)
  );

  sat_counter #(.W(TRACK_W)) u_width (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .load  (width_load),
    .inc   (width_inc),
    .count (width),
    .sat   (width_sat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle counter controls
  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    width_load  = 1'b0;
    width_inc   = 1'b0;
    gap_start   = 1'b0;
    gap_inc     = 1'b0;
    burst_start = 1'b0;
    set_wide    = 1'b0;
    set_ovf     = 1'b0;
    case (state)
      IDLE, DONE: begin
        // A high sample in DONE is already the first pulse of the next burst
        if (pulse) begin
          next_state  = HIGH;
          cnt_load    = 1'b1;
          width_load  = 1'b1;
          burst_start = 1'b1;
        end else begin
          next_state  = IDLE;
        end
      end
      HIGH: begin
        if (pulse) begin
          width_inc = 1'b1;
          // A width pinned at its ceiling is necessarily past the legal limit
          if (width == MAX_W || width_sat) set_wide = 1'b1;
        end else begin
          next_state = GAP;
          gap_start  = 1'b1;
        end
      end
      GAP: begin
        if (pulse) begin
          next_state = HIGH;
          width_load = 1'b1;
          if (cnt_sat) set_ovf = 1'b1;
          else         cnt_inc = 1'b1;
        end else if (gap < GAP_LAST) begin
          gap_inc = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign done_enter = (state == GAP) && (next_state == DONE);

  // Consecutive-low tracker; zero whenever not counting a gap
  always_ff @(posedge clk) begin
    if (reset) begin
      gap <= '0;
    end else if (gap_start) begin
      gap <= {{(TRACK_W-1){1'b0}}, 1'b1};
    end else if (gap_inc) begin
      gap <= gap + 1'b1;
    end else begin
      gap <= '0;
    end
  end

  // Sticky per-burst error flags, rearmed by the first pulse of a burst
  always_ff @(posedge clk) begin
    if (reset || burst_start) begin
      wide_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (set_wide) wide_err <= 1'b1;
      if (set_ovf)  ovf      <= 1'b1;
    end
  end

  // Result registers: strobe and verdict line up with the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_done <= 1'b0;
      burst_len  <= '0;
      burst_ok   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      burst_done <= done_enter;
      if (done_enter) begin
        burst_len <= cnt;
        burst_ok  <= (32'(cnt) == EXPECTED_PULSES) && !wide_err && !ovf;
      end
    end
  end

  // Completed-burst tally, bumped as DONE retires so a coincident clear wins
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      burst_total <= '0;
    end else if (state == DONE) begin
      burst_total <= burst_total + 1'b1;
    end
  end

`ifdef PULSE_DEC_ERRCNT_EN
  logic err_sat;

  sat_counter #(.W(8)) u_err (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .load  (1'b0),
    .inc   ((state == DONE) && !burst_ok && !err_sat),
    .count (err_count),
    .sat   (err_sat)
  );
`else
  // Failed-burst tally not built
`endif

endmodule

// File: tb/tb_pulse_burst_decoder.sv
// tb/tb_pulse_burst_decoder.sv - scoreboard bench for pulse_burst_decoder (CNT_W=5 and CNT_W=3 instances)
module tb_pulse_burst_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse = 1'b0;
  logic       clear = 1'b0;

  logic       a_done, a_ok, a_busy;
  logic [4:0] a_len;
  logic [7:0] a_total;
  logic       b_done, b_ok, b_busy;
  logic [2:0] b_len;
  logic [7:0] b_total;
`ifdef PULSE_DEC_ERRCNT_EN
  logic [7:0] a_err, b_err;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int len;
    int ok;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  pulse_burst_decoder #(.CNT_W(5)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .clear       (clear),
    .burst_done  (a_done),
    .burst_len   (a_len),
    .burst_ok    (a_ok),
    .busy        (a_busy),
    .burst_total (a_total)
`ifdef PULSE_DEC_ERRCNT_EN
    ,
    .err_count   (a_err)
`endif
  );

  pulse_burst_decoder #(.CNT_W(3)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .clear       (clear),
    .burst_done  (b_done),
    .burst_len   (b_len),
    .burst_ok    (b_ok),
    .busy        (b_busy),
    .burst_total (b_total)
`ifdef PULSE_DEC_ERRCNT_EN
    ,
    .err_count   (b_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop the expected result whenever a strobe appears
  always @(negedge clk) begin
    exp_t e;
    if (!reset && a_done) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done actual=len%0d expected=no_strobe", a_len);
      end else begin
        e = qa.pop_front();
        check("a_len", int'(a_len), e.len);
        check("a_ok", int'(a_ok), e.ok);
        check("a_latency_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && b_done) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done actual=len%0d expected=no_strobe", b_len);
      end else begin
        e = qb.pop_front();
        check("b_len", int'(b_len), e.len);
        check("b_ok", int'(b_ok), e.ok);
        check("b_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  // n pulses separated by single lows; pulse index wide_idx is held for 2 cycles
  task automatic pulses(input int n, input int wide_idx);
    for (int i = 0; i < n; i++) begin
      if (i > 0) drive(1'b0);
      drive(1'b1);
      if (i == wide_idx) drive(1'b1);
    end
  endtask

  // Three terminating lows; strobe expected in the cycle after the third
  task automatic end_burst(input int la, input int oa, input int lb, input int ob);
    exp_t e;
    drive(1'b0);
    drive(1'b0);
    e.cyc = cyc + 1;
    e.len = la; e.ok = oa; qa.push_back(e);
    e.len = lb; e.ok = ob; qb.push_back(e);
    drive(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", int'(a_done), 0);
    check("reset_len", int'(a_len), 0);
    check("reset_ok", int'(a_ok), 0);
    check("reset_busy", int'(a_busy), 0);
    check("reset_total", int'(a_total), 0);
    reset = 1'b0;
    idle(2);

    // Clean 8-pulse burst; the 3-bit instance saturates
    pulses(8, -1);
    check("busy_mid_burst", int'(a_busy), 1);
    end_burst(8, 1, 7, 0);
    idle(3);
    check("total_after_1", int'(a_total), 1);
    check("busy_after_burst", int'(a_busy), 0);

    // Short burst
    pulses(7, -1);
    end_burst(7, 0, 7, 0);
    idle(3);
    check("total_after_2", int'(a_total), 2);
`ifdef PULSE_DEC_ERRCNT_EN
    check("err_count_after_short", int'(a_err), 1);
`endif

    // Pulse #4 too wide
    pulses(8, 3);
    end_burst(8, 0, 7, 0);
    idle(3);

    // Two-low intra-burst gap does not split the burst
    pulses(4, -1);
    idle(2);
    pulses(4, -1);
    end_burst(8, 1, 7, 0);
    idle(3);

    // Ten pulses
    pulses(10, -1);
    end_burst(10, 0, 7, 0);
    idle(3);
    check("total_after_5", int'(a_total), 5);

    // Reset mid-burst discards the partial burst
    pulses(5, -1);
    reset = 1'b1;
    drive(1'b0);
    check("midreset_busy", int'(a_busy), 0);
    check("midreset_len", int'(a_len), 0);
    check("midreset_ok", int'(a_ok), 0);
    check("midreset_total", int'(a_total), 0);
    check("midreset_b_len", int'(b_len), 0);
    reset = 1'b0;
    idle(2);
    pulses(8, -1);
    end_burst(8, 1, 7, 0);
    idle(3);
    check("total_after_reset_burst", int'(a_total), 1);

    // clear coincident with DONE
    pulses(8, -1);
    end_burst(8, 1, 7, 0);
    clear = 1'b1;
    drive(1'b0);
    clear = 1'b0;
    idle(2);
    check("clear_in_done_total", int'(a_total), 0);
    check("clear_in_done_b_total", int'(b_total), 0);

    // Next burst starts with a pulse during the DONE cycle
    pulses(8, -1);
    end_burst(8, 1, 7, 0);
    pulses(8, -1);
    end_burst(8, 1, 7, 0);
    idle(5);
    check("total_back_to_back", int'(a_total), 2);
    check("b_busy_idle", int'(b_busy), 0);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
